// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared types and default constants for the fetch controller
package fetch_pkg;

  // FSM encoding is exported on the debug state port, so values are pinned
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    EXC    = 2'd3
  } fetch_state_t;

  // Source of the next program counter value
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_JMP,
    SEL_EXC
  } pc_sel_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
  localparam int          DEF_PC_STEP   = 4;
  localparam int          DEF_CNT_W     = 32;

  // Redirect targets are forced onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // A redirect target is misaligned when its low two bits are not zero
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - pipeline-side signal bundle of the fetch controller
interface fetch_controller_if #(
  parameter int CNT_W = 32
);

  // Requests from the pipeline stages
  logic             hazard_stall;
  logic             imem_wait;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic             exception;
  logic             halt_req;
  logic             resume;

  // Controls and status back to the pipeline
  logic [31:0]      pc;
  logic             if_stall;
  logic             if_flush;
  logic             id_flush;
  logic             misalign;
  logic [1:0]       state;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: raises requests, consumes pc and controls
  modport master (
    output hazard_stall, imem_wait, branch_taken, branch_target,
           jump, jump_target, exception, halt_req, resume,
    input  pc, if_stall, if_flush, id_flush, misalign, state,
           fetch_cnt, redirect_cnt, stall_cnt
  );

  // Controller side: consumes requests, produces pc and controls
  modport slave (
    input  hazard_stall, imem_wait, branch_taken, branch_target,
           jump, jump_target, exception, halt_req, resume,
    output pc, if_stall, if_flush, id_flush, misalign, state,
           fetch_cnt, redirect_cnt, stall_cnt
  );

endinterface

// File: rtl/fetch_controller_sat_counter.sv
// rtl/fetch_controller_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  // Count accepted events, holding at the maximum instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - program counter owner and IF/ID sequencing controller
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          PC_STEP   = DEF_PC_STEP,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.slave  bus
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_misalign;
  logic         w_misalign_nxt;
  pc_sel_t      w_sel;
  logic         w_if_stall;
  logic         w_if_flush;
  logic         w_id_flush;
  logic         w_redirect;
  logic         w_fetch;

  // Next-state, pc source and pipeline controls; RUN priority is
  // exception > branch > jump > halt > stall > sequential, losers are dropped
  always_comb begin
    w_state_nxt    = r_state;
    w_sel          = SEL_HOLD;
    w_if_stall     = 1'b0;
    w_if_flush     = 1'b0;
    w_id_flush     = 1'b0;
    w_redirect     = 1'b0;
    w_misalign_nxt = 1'b0;
    case (r_state)
      BOOT: begin
        w_if_flush  = 1'b1;
        w_id_flush  = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.exception) begin
          w_sel       = SEL_EXC;
          w_if_flush  = 1'b1;
          w_id_flush  = 1'b1;
          w_redirect  = 1'b1;
          w_state_nxt = EXC;
        end else if (bus.branch_taken) begin
          w_sel          = SEL_BR;
          w_if_flush     = 1'b1;
          w_id_flush     = 1'b1;
          w_redirect     = 1'b1;
          w_misalign_nxt = is_misaligned(bus.branch_target);
        end else if (bus.jump) begin
          w_sel          = SEL_JMP;
          w_if_flush     = 1'b1;
          w_redirect     = 1'b1;
          w_misalign_nxt = is_misaligned(bus.jump_target);
        end else if (bus.halt_req) begin
          w_if_flush  = 1'b1;
          w_state_nxt = HALTED;
        end else if (bus.hazard_stall || bus.imem_wait) begin
          w_if_stall = 1'b1;
        end else begin
          w_sel = SEL_SEQ;
        end
      end
      HALTED: begin
        // Keep draining NOPs; only exception or resume can leave
        w_if_flush = 1'b1;
        if (bus.exception) begin
          w_sel       = SEL_EXC;
          w_id_flush  = 1'b1;
          w_redirect  = 1'b1;
          w_state_nxt = EXC;
        end else if (bus.resume) begin
          w_state_nxt = RUN;
        end
      end
      EXC: begin
        w_if_flush = 1'b1;
        w_id_flush = 1'b1;
        if (bus.exception) begin
          w_sel      = SEL_EXC;
          w_redirect = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  // Next program counter from the selected source
  always_comb begin
    w_pc_nxt = r_pc;
    case (w_sel)
      SEL_SEQ:  w_pc_nxt = r_pc + STEP;
      SEL_BR:   w_pc_nxt = word_align(bus.branch_target);
      SEL_JMP:  w_pc_nxt = word_align(bus.jump_target);
      SEL_EXC:  w_pc_nxt = EXC_VEC;
      default:  w_pc_nxt = r_pc;
    endcase
  end

  // State, pc and misalign pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign w_fetch = (r_state == RUN) && !w_if_stall && !w_if_flush;

  sat_counter #(.WIDTH(CNT_W)) u_fetch_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_fetch),
    .o_count (bus.fetch_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_redirect),
    .o_count (bus.redirect_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_if_stall),
    .o_count (bus.stall_cnt)
  );

  assign bus.pc       = r_pc;
  assign bus.if_stall = w_if_stall;
  assign bus.if_flush = w_if_flush;
  assign bus.id_flush = w_id_flush;
  assign bus.misalign = r_misalign;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fetch_controller_if #(.CNT_W(32)) bus ();

  fetch_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hazard_stall  = 1'b0;
    bus.imem_wait     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'h0;
    bus.exception     = 1'b0;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;
  endtask

  task automatic do_jump(input logic [31:0] tgt);
    bus.jump        = 1'b1;
    bus.jump_target = tgt;
    step();
    clear_inputs();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    clear_inputs();
    step();
    step();

    // In reset
    check("rst_pc", bus.pc, 32'h0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_if_flush", 32'(bus.if_flush), 32'd1);
    check("rst_id_flush", 32'(bus.id_flush), 32'd1);
    check("rst_if_stall", 32'(bus.if_stall), 32'd0);
    check("rst_fetch_cnt", bus.fetch_cnt, 32'd0);

    // BOOT then sequential fetch
    rst = 1'b1;
    #1;
    check("boot_state", 32'(bus.state), 32'd0);
    check("boot_pc", bus.pc, 32'h0);
    check("boot_if_flush", 32'(bus.if_flush), 32'd1);
    step();
    check("run0_state", 32'(bus.state), 32'd1);
    check("run0_pc", bus.pc, 32'h0);
    check("run0_if_flush", 32'(bus.if_flush), 32'd0);
    check("run0_id_flush", 32'(bus.id_flush), 32'd0);
    step();
    check("run1_pc", bus.pc, 32'h4);
    step();
    check("run2_pc", bus.pc, 32'h8);
    check("run2_fetch_cnt", bus.fetch_cnt, 32'd2);

    // Branch beats jump in the same cycle
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    bus.jump          = 1'b1;
    bus.jump_target   = 32'h200;
    #1;
    check("br_if_flush", 32'(bus.if_flush), 32'd1);
    check("br_id_flush", 32'(bus.id_flush), 32'd1);
    step();
    clear_inputs();
    check("br_pc", bus.pc, 32'h100);
    check("br_redirect_cnt", bus.redirect_cnt, 32'd1);
    check("br_misalign", 32'(bus.misalign), 32'd0);

    // Jump flushes IF only
    bus.jump        = 1'b1;
    bus.jump_target = 32'h40;
    #1;
    check("jmp_if_flush", 32'(bus.if_flush), 32'd1);
    check("jmp_id_flush", 32'(bus.id_flush), 32'd0);
    step();
    clear_inputs();
    check("jmp_pc", bus.pc, 32'h40);

    // Three-cycle load-use stall
    bus.hazard_stall = 1'b1;
    #1;
    check("stall_if_stall", 32'(bus.if_stall), 32'd1);
    check("stall_if_flush", 32'(bus.if_flush), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.pc, 32'h40);
    end
    bus.hazard_stall = 1'b0;
    #1;
    check("stall_cnt", bus.stall_cnt, 32'd3);
    check("stall_release", 32'(bus.if_stall), 32'd0);
    step();
    check("stall_next_pc", bus.pc, 32'h44);

    // Exception wins over halt and imem wait
    bus.exception = 1'b1;
    bus.halt_req  = 1'b1;
    bus.imem_wait = 1'b1;
    #1;
    check("exc_if_flush", 32'(bus.if_flush), 32'd1);
    check("exc_id_flush", 32'(bus.id_flush), 32'd1);
    check("exc_if_stall", 32'(bus.if_stall), 32'd0);
    step();
    clear_inputs();
    #1;
    check("exc_pc", bus.pc, 32'h80);
    check("exc_state", 32'(bus.state), 32'd3);
    check("exc_state_flush", 32'(bus.id_flush), 32'd1);
    step();
    check("exc_run_state", 32'(bus.state), 32'd1);
    check("exc_run_pc", bus.pc, 32'h80);
    step();
    check("exc_seq_pc", bus.pc, 32'h84);
    check("exc_redirect_cnt", bus.redirect_cnt, 32'd3);

    // Halt at 0x20 with stall requests ignored, resume after 5 cycles
    do_jump(32'h20);
    check("halt_pc0", bus.pc, 32'h20);
    bus.halt_req = 1'b1;
    step();
    clear_inputs();
    bus.hazard_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("halt_state", 32'(bus.state), 32'd2);
      check("halt_if_flush", 32'(bus.if_flush), 32'd1);
      check("halt_if_stall", 32'(bus.if_stall), 32'd0);
      check("halt_pc", bus.pc, 32'h20);
      step();
    end
    bus.hazard_stall = 1'b0;
    check("halt_stall_cnt", bus.stall_cnt, 32'd3);
    bus.resume = 1'b1;
    step();
    clear_inputs();
    check("resume_state", 32'(bus.state), 32'd1);
    check("resume_pc", bus.pc, 32'h20);
    step();
    check("resume_next_pc", bus.pc, 32'h24);

    // Misaligned jump target
    do_jump(32'h103);
    check("mis_pc", bus.pc, 32'h100);
    check("mis_pulse", 32'(bus.misalign), 32'd1);
    step();
    check("mis_pulse_end", 32'(bus.misalign), 32'd0);
    check("mis_next_pc", bus.pc, 32'h104);

    // Wrap-around at the top of the address space
    do_jump(32'hFFFF_FFFC);
    check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_misalign", 32'(bus.misalign), 32'd0);
    step();
    check("wrap_next_pc", bus.pc, 32'h0);
    check("wrap_redirect_cnt", bus.redirect_cnt, 32'd6);

    // Asynchronous reset mid-run
    step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'h0);
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_redirect_cnt", bus.redirect_cnt, 32'd0);
    check("arst_stall_cnt", bus.stall_cnt, 32'd0);
    check("arst_fetch_cnt", bus.fetch_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Owns the program counter and sequences the instruction-fetch stage. It drives pc_in of the IF stage and generates that stage's stall and flush controls. It also generates the ID/EX flush. It arbitrates between competing redirect sources (exception, EX branch, ID jump), the decode load-use hazard, instruction-memory wait and halt/resume. It keeps saturating performance counters.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset exit
EXC_VEC, 32'h0000_0080, PC loaded on exception
PC_STEP, 4, sequential increment in bytes
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
hazard_stall  in  1  load-use stall request from decode
imem_wait  in  1  instruction memory not ready this cycle
branch_taken  in  1  EX-stage branch resolved taken
branch_target  in  32  EX-stage branch target
jump  in  1  ID-stage unconditional jump
jump_target  in  32  ID-stage jump target
exception  in  1  exception raised (any stage)
halt_req  in  1  halt instruction decoded
resume  in  1  leave HALTED
pc  out  32  current fetch address (registered), to IF pc_in
if_stall  out  1  hold IF/ID register (combinational)
if_flush  out  1  bubble IF/ID register (combinational)
id_flush  out  1  bubble ID/EX register (combinational)
misalign  out  1  one-cycle pulse: redirect target had [1:0]!=0
state  out  2  FSM state, for debug
fetch_cnt  out  CNT_W  instructions fetched (saturating)
redirect_cnt  out  CNT_W  redirects taken (saturating)
stall_cnt  out  CNT_W  cycles with if_stall=1 (saturating)

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_VEC; state=BOOT; misalign=0; all counters=0.
  - if_stall=0, if_flush=1, id_flush=1 while in reset and while in BOOT.
- States (2-bit encoding):
  - BOOT=0: one cycle, then RUN. pc is unchanged, so the first fetch is RESET_VEC.
  - RUN=1: normal fetch.
  - HALTED=2: stopped.
  - EXC=3: one-cycle exception flush, then RUN.
- Per-cycle priority in RUN (highest first). Each outcome gives the next pc and the outputs asserted this cycle:
  1. exception: pc<=EXC_VEC; if_flush=1, id_flush=1; next state EXC.
  2. branch_taken: pc<=branch_target&~3; if_flush=1, id_flush=1.
  3. jump: pc<=jump_target&~3; if_flush=1; id_flush=0.
  4. halt_req: pc holds; if_flush=1; next state HALTED.
  5. hazard_stall or imem_wait: pc holds; if_stall=1.
  6. Otherwise: pc<=pc+PC_STEP, using 32-bit wrap-around (FFFF_FFFC -> 0000_0000).
- Lower-priority requests in the same cycle are dropped, not queued. Source stages re-present them if still valid.
- if_flush and if_stall are never both 1 in the same cycle. The IF stage gives flush priority.
- misalign pulses for exactly the cycle after a branch or jump redirect whose target[1:0]!=0. The pc is still taken as target with bits [1:0] forced to 00.
- EXC state: if_flush=1, id_flush=1, pc holds EXC_VEC; next state RUN. An exception arriving in EXC reloads EXC_VEC and stays in EXC.
- HALTED state:
  - pc holds; if_flush=1 every cycle, so NOPs drain; if_stall=0.
  - resume -> RUN next cycle, fetch continuing at the held pc.
  - exception overrides resume: pc<=EXC_VEC, next state EXC.
  - All other inputs are ignored.
- Counters (each saturates at all-ones, never wraps):
  - fetch_cnt increments on every RUN cycle with no stall and no flush.
  - redirect_cnt increments on every exception, branch or jump acceptance.
  - stall_cnt increments on every cycle with if_stall=1.
- Reset mid-operation (any state) aborts immediately to the reset values above. Counters clear.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic[1:0] fetch_state_t {BOOT, RUN, HALTED, EXC};
  - typedef enum next-pc select {SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JMP, SEL_EXC};
  - default vector constants.
- One natural sub-module, sat_counter (parameter width, inc, async active-low reset), instantiated three times.
- Next-pc select and FSM stay in fetch_controller.

Test Plan:
- Reset release, no requests for 4 cycles -> pc = 0x0, 0x0 (BOOT), 0x4, 0x8; if_flush=1 only during reset and BOOT; fetch_cnt=2.
- Branch and jump in the same cycle (branch_target=0x100, jump_target=0x200) -> next pc=0x100; if_flush=id_flush=1; redirect_cnt +1.
- hazard_stall for 3 cycles at pc=0x40 -> pc holds 0x40; if_stall=1 for 3 cycles; stall_cnt=3; then pc=0x44.
- exception while halt_req and imem_wait are high -> pc=0x80; state EXC one cycle, then RUN; pc=0x84 the following cycle.
- halt_req at pc=0x20, then resume after 5 cycles -> if_flush=1 throughout HALTED; pc stays 0x20; after resume pc=0x20 then 0x24.
- jump_target=0x103, plus a separate run with pc=FFFF_FFFC and no requests -> misalign pulse and pc=0x100; pc wraps to 0x0.
